// File: rtl/delay_ctrl_pkg.sv
// Shared types and helpers for the delay-line latency controller.
package delay_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } delay_ctrl_state_e;

    // Cycles needed after a latency change before the delay line output is trustworthy.
    function automatic int unsigned settle_cycles(input int unsigned size, input int unsigned latency);
        return (32'd1 << size) + latency + 32'd1;
    endfunction

endpackage

// File: rtl/delayfifo.sv
// Variable delay line: din reappears on dout latency+1 cycles later, over a 2^SIZE entry memory.
module delayfifo #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [SIZE-1:0]      latency,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << SIZE;

    logic [BIT_WIDTH-1:0] mem_r [DEPTH];
    logic [SIZE-1:0]      wr_ptr_r;
    logic [SIZE-1:0]      rd_ptr_s;
    logic [BIT_WIDTH-1:0] dout_r;

    assign rd_ptr_s = wr_ptr_r - latency;
    assign dout     = dout_r;

    // Sample memory; never cleared, stale contents are hidden by the controller's mute window
    always_ff @(posedge clk) begin
        mem_r[wr_ptr_r] <= din;
    end

    // Write pointer and read register; zero latency bypasses the memory to avoid a same-cycle read
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {SIZE{1'b0}};
            dout_r   <= {BIT_WIDTH{1'b0}};
        end else begin
            wr_ptr_r <= wr_ptr_r + {{(SIZE-1){1'b0}}, 1'b1};
            if (latency == {SIZE{1'b0}}) begin
                dout_r <= din;
            end else begin
                dout_r <= mem_r[rd_ptr_s];
            end
        end
    end

endmodule

// File: rtl/delay_latency_ctrl.sv
// Latency controller around a delayfifo: accepts latency changes and blanks the output while it settles.
// Build option DELAYCTRL_LINESYNC_EN defers each accepted change to the next line_start.
module delay_latency_ctrl
    import delay_ctrl_pkg::*;
#(
    parameter int                   BIT_WIDTH   = 8,
    parameter int                   SIZE        = 5,
    parameter logic [BIT_WIDTH-1:0] BLANK_VALUE = {BIT_WIDTH{1'b0}}
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 line_start,
    input  logic                 cfg_valid,
    input  logic [SIZE-1:0]      cfg_latency,
    output logic                 cfg_ready,
    input  logic [BIT_WIDTH-1:0] in,
    output logic [BIT_WIDTH-1:0] out,
    output logic                 out_valid,
    output logic [SIZE-1:0]      active_latency,
    output logic                 busy
);

    localparam int CNT_W = SIZE + 2;
    localparam logic [CNT_W-1:0] CNT_RESET = CNT_W'(settle_cycles(SIZE, 32'd0) - 32'd1);

    delay_ctrl_state_e    state_r, state_nxt_s;
    logic [CNT_W-1:0]     settle_cnt_r;
    logic [CNT_W-1:0]     cnt_load_s;
    logic [SIZE-1:0]      active_latency_r;
    logic [SIZE-1:0]      pending_latency_r;
    logic [SIZE-1:0]      apply_lat_s;
    logic                 apply_s;
    logic                 capture_s;
    logic                 mute_s;
    logic [BIT_WIDTH-1:0] dly_out_s;
    logic [BIT_WIDTH-1:0] out_r;
    logic                 out_valid_r;

`ifndef DELAYCTRL_LINESYNC_EN
    logic unused_line_start_s;
    assign unused_line_start_s = line_start;
`endif

    assign cnt_load_s     = CNT_W'(settle_cycles(SIZE, 32'(apply_lat_s)) - 32'd1);
    assign mute_s         = (state_r == SETTLE);
    assign cfg_ready      = (state_r == RUN);
    assign busy           = (state_r != RUN);
    assign active_latency = active_latency_r;
    assign out            = out_r;
    assign out_valid      = out_valid_r;

    delayfifo #(
        .BIT_WIDTH (BIT_WIDTH),
        .SIZE      (SIZE)
    ) u_delayfifo (
        .clk     (clk),
        .reset   (reset),
        .latency (active_latency_r),
        .din     (in),
        .dout    (dly_out_s)
    );

    // Next state, request capture and latency apply decisions
    always_comb begin
        state_nxt_s = state_r;
        capture_s   = 1'b0;
        apply_s     = 1'b0;
        apply_lat_s = pending_latency_r;
        case (state_r)
            RUN: begin
                if (cfg_valid && (cfg_latency != active_latency_r)) begin
                    capture_s = 1'b1;
`ifdef DELAYCTRL_LINESYNC_EN
                    state_nxt_s = PENDING;
`else
                    state_nxt_s = SETTLE;
                    apply_s     = 1'b1;
                    apply_lat_s = cfg_latency;
`endif
                end else begin
                    state_nxt_s = RUN;
                end
            end
            PENDING: begin
`ifdef DELAYCTRL_LINESYNC_EN
                if (line_start) begin
                    state_nxt_s = SETTLE;
                    apply_s     = 1'b1;
                end else begin
                    state_nxt_s = PENDING;
                end
`else
                state_nxt_s = SETTLE;
                apply_s     = 1'b1;
`endif
            end
            SETTLE: begin
                if (settle_cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = SETTLE;
                end
            end
            default: begin
                // Illegal encoding: re-enter a full mute window with the last captured latency
                state_nxt_s = SETTLE;
                apply_s     = 1'b1;
            end
        endcase
    end

    // FSM state, latency registers and settle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r           <= SETTLE;
            settle_cnt_r      <= CNT_RESET;
            active_latency_r  <= {SIZE{1'b0}};
            pending_latency_r <= {SIZE{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                pending_latency_r <= cfg_latency;
            end
            if (apply_s) begin
                active_latency_r <= apply_lat_s;
                settle_cnt_r     <= cnt_load_s;
            end else if ((state_r == SETTLE) && (settle_cnt_r != {CNT_W{1'b0}})) begin
                settle_cnt_r <= settle_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Output register: blanking value while muted, delayed sample otherwise
    always_ff @(posedge clk) begin
        if (reset || mute_s) begin
            out_r       <= BLANK_VALUE;
            out_valid_r <= 1'b0;
        end else begin
            out_r       <= dly_out_s;
            out_valid_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_delay_latency_ctrl.sv
// Directed bench for delay_latency_ctrl with a ramp input and an input-history scoreboard.
module tb_delay_latency_ctrl;

    localparam int BW = 8;
    localparam int SZ = 5;
    localparam logic [BW-1:0] BLANK = 8'd0;

    logic          clk = 1'b0;
    logic          reset;
    logic          line_start;
    logic          cfg_valid;
    logic [SZ-1:0] cfg_latency;
    logic          cfg_ready;
    logic [BW-1:0] in;
    logic [BW-1:0] out;
    logic          out_valid;
    logic [SZ-1:0] active_latency;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_lat = 0;
    bit mon_en = 1'b0;
    logic [BW-1:0] hist[$];
    int n_low, busy_k, bad, drops, k;

    always #5 clk = ~clk;

    delay_latency_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .line_start     (line_start),
        .cfg_valid      (cfg_valid),
        .cfg_latency    (cfg_latency),
        .cfg_ready      (cfg_ready),
        .in             (in),
        .out            (out),
        .out_valid      (out_valid),
        .active_latency (active_latency),
        .busy           (busy)
    );

    function automatic int nset(input int lat);
        return (1 << SZ) + lat + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: advance the ramp, record it, and score the delayed output.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        in = BW'(cyc);
        hist.push_back(in);
        if (hist.size() > 64) void'(hist.pop_front());
        if (mon_en && out_valid === 1'b1 && hist.size() > exp_lat + 2)
            chk("data", out, hist[hist.size() - 3 - exp_lat]);
    endtask

    task automatic wait_valid(output int nl, output int bk);
        int blank_bad;
        nl = 0; bk = 0; blank_bad = 0;
        while (nl < 300) begin
            tick();
            if (bk == 0 && busy === 1'b0) bk = nl + 1;
            if (out_valid === 1'b1) break;
            if (out !== BLANK) blank_bad++;
            nl++;
        end
        chk("mute_blank", blank_bad, 0);
    endtask

    task automatic sync_line();
`ifdef DELAYCTRL_LINESYNC_EN
        for (int i = 0; i < 5; i++) begin
            chk("pend_active", active_latency, exp_lat);
            chk("pend_busy", busy, 1);
            tick();
        end
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
`endif
    endtask

    task automatic change(input int lat, input string tag);
        int nl, bk;
        cfg_valid = 1'b1;
        cfg_latency = SZ'(lat);
        chk({tag, "_ready"}, cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk({tag, "_ready_drop"}, cfg_ready, 0);
        sync_line();
        chk({tag, "_active"}, active_latency, lat);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_valid_t1"}, out_valid, 1);
        exp_lat = lat;
        wait_valid(nl, bk);
        chk({tag, "_mute_len"}, nl, nset(lat));
        chk({tag, "_busy_fall"}, bk, nset(lat));
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; cfg_valid = 1'b0; cfg_latency = 5'd0; in = 8'd0;
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, BLANK);
        chk("rst_active", active_latency, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", busy, 1);

        // Test 1: reset release mute window, then ramp at latency 0
        reset = 1'b0;
        chk("rst_c0_valid", out_valid, 0);
        wait_valid(n_low, busy_k);
        chk("rst_mute_len", n_low, 33);
        chk("rst_busy_fall", busy_k, 33);
        chk("rst_active_run", active_latency, 0);
        mon_en = 1'b1;
        exp_lat = 0;
        repeat (8) tick();

        // line_start in RUN has no effect
        line_start = 1'b1; tick(); line_start = 1'b0;
        chk("ls_run_busy", busy, 0);
        tick();
        chk("ls_run_valid", out_valid, 1);
        chk("ls_run_active", active_latency, 0);

        // Tests 2 and boundary latencies
        change(10, "l10");
        repeat (20) tick();
        change(31, "l31");
        repeat (40) tick();
        change(7, "l7");
        repeat (12) tick();

        // Test 3: same-latency request is a no-op
        cfg_valid = 1'b1; cfg_latency = 5'd7;
        chk("same_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        chk("same_ready_t1", cfg_ready, 1);
        chk("same_busy_t1", busy, 0);
        drops = 0; bad = 0;
        repeat (45) begin
            tick();
            if (out_valid !== 1'b1) drops++;
            if (busy !== 1'b0 || active_latency !== 5'd7) bad++;
        end
        chk("same_no_drop", drops, 0);
        chk("same_no_change", bad, 0);

        // Test 6: L=20 held valid through the L=4 settle, accepted once on return to RUN
        cfg_valid = 1'b1; cfg_latency = 5'd4;
        chk("hold_ready0", cfg_ready, 1);
        tick();
        cfg_latency = 5'd20;
        sync_line();
        exp_lat = 4;
        k = 0; bad = 0;
        while (cfg_ready !== 1'b1 && k < 300) begin
            if (active_latency !== 5'd4) bad++;
            tick();
            k++;
        end
        chk("hold_wait", k, nset(4));
        chk("hold_active_kept", bad, 0);
        chk("hold_active_pre", active_latency, 4);
        tick();
        cfg_valid = 1'b0;
        chk("hold_ready_drop", cfg_ready, 0);
        sync_line();
        chk("hold_active_post", active_latency, 20);
        chk("hold_busy", busy, 1);
        exp_lat = 20;

        // Test 5: reset in the middle of the L=20 settle
        repeat (10) tick();
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_active", active_latency, 0);
        chk("mid_rst_out", out, BLANK);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", cfg_ready, 0);
        chk("mid_rst_busy", busy, 1);
        reset = 1'b0;
        exp_lat = 0;
        wait_valid(n_low, busy_k);
        chk("mid_rst_mute_len", n_low, 33);
        chk("mid_rst_busy_fall", busy_k, 33);
        repeat (10) tick();

`ifdef DELAYCTRL_LINESYNC_EN
        // Test 4: same-cycle line_start ignored, change applied on a line_start 100 cycles later
        cfg_valid = 1'b1; cfg_latency = 5'd3; line_start = 1'b1;
        chk("ls_ready", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0; line_start = 1'b0;
        chk("ls_busy", busy, 1);
        chk("ls_ready_drop", cfg_ready, 0);
        bad = 0;
        repeat (99) begin
            if (active_latency !== 5'd0 || out_valid !== 1'b1) bad++;
            tick();
        end
        chk("ls_pending_hold", bad, 0);
        line_start = 1'b1;
        chk("ls_active_before", active_latency, 0);
        tick();
        line_start = 1'b0;
        chk("ls_active_after", active_latency, 3);
        chk("ls_valid_t1", out_valid, 1);
        exp_lat = 3;
        wait_valid(n_low, busy_k);
        chk("ls_mute_len", n_low, 36);
        repeat (10) tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
